// File: rtl/usb_rx_port_pkg.sv
// Shared definitions for the USB receive port.
// Status bit positions, strobe FSM state codes, status packing helper.
package usb_rx_port_pkg;

    localparam int STAT_RX_AVAIL = 0;
    localparam int STAT_TX_READY = 1;
    localparam int STAT_RX_FULL  = 2;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_STROBE  = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_RECOVER = 2'd3;

    function automatic logic [7:0] pack_status(
        input logic rx_avail,
        input logic tx_ready,
        input logic rx_full
    );
        logic [7:0] s;
        s                = 8'h00;
        s[STAT_RX_AVAIL] = rx_avail;
        s[STAT_TX_READY] = tx_ready;
        s[STAT_RX_FULL]  = rx_full;
        return s;
    endfunction

endpackage

// File: rtl/usb_rx_port_fifo.sv
// Synchronous show-ahead byte FIFO for the USB receive port.
// Head byte is visible on dout_o combinationally; push/pop gated internally.
module usb_rx_fifo
    import usb_rx_port_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [7:0]               din_i,
    input  logic                     pop_i,
    output logic [7:0]               dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] wr_d;
    logic [AW-1:0] rd_q;
    logic [AW-1:0] rd_d;
    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_d;
    logic          push_ok;
    logic          pop_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is 2^n)
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_ok) begin
            wr_d = wr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_d = rd_q + AW'(1);
        end
        cnt_d = cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_q] <= din_i;
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/usb_rx_port.sv
// FT245-style USB receive port: read strobe FSM, byte FIFO, CPU status.
// Optional rx_irq output is built when USB_RX_IRQ_EN is defined.
module usb_rx_port
    import usb_rx_port_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int RD_LOW_CYCLES  = 16,
    parameter int RD_RECOVER_CYC = 24
) (
    input  logic       pll0_250MHz,
    input  logic       reset,
    input  logic       usb_rxf_n,
    input  logic       usb_txe_n,
    input  logic [7:0] usb_d_in,
    output logic       usb_rd_n,
    input  logic       usbRxD_cs,
    output logic [7:0] usbRxD,
    output logic [7:0] usbStatus
`ifdef USB_RX_IRQ_EN
    ,
    output logic       rx_irq
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = 8;

    logic [1:0]    rxf_s_q;
    logic [1:0]    txe_s_q;
    logic          rxf_sync;
    logic          txe_sync;

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [TW-1:0] tmr_q;
    logic [TW-1:0] tmr_d;
    logic          rd_n_q;
    logic          rd_n_d;
    logic [7:0]    data_q;
    logic [7:0]    data_d;
    logic          push;

    logic          cs_q;
    logic          cs_prev_q;
    logic          pop;

    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;

    logic [7:0]    rxd_q;
    logic [7:0]    status_q;

    assign rxf_sync = rxf_s_q[1];
    assign txe_sync = txe_s_q[1];

    // Two-flop synchronizers; reset to the idle (high) level of both flags
    always_ff @(posedge pll0_250MHz) begin
        if (reset) begin
            rxf_s_q <= 2'b11;
            txe_s_q <= 2'b11;
        end else begin
            rxf_s_q <= {rxf_s_q[0], usb_rxf_n};
            txe_s_q <= {txe_s_q[0], usb_txe_n};
        end
    end

    // Read strobe sequencing; a strobe only starts when the FIFO has room
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        rd_n_d  = rd_n_q;
        data_d  = data_q;
        push    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!rxf_sync && !fifo_full) begin
                    state_d = ST_STROBE;
                    rd_n_d  = 1'b0;
                    tmr_d   = '0;
                end
            end
            ST_STROBE: begin
                if (tmr_q == TW'(RD_LOW_CYCLES - 1)) begin
                    data_d  = usb_d_in;
                    rd_n_d  = 1'b1;
                    state_d = ST_CAPTURE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            ST_CAPTURE: begin
                push    = 1'b1;
                tmr_d   = '0;
                state_d = ST_RECOVER;
            end
            ST_RECOVER: begin
                if (tmr_q == TW'(RD_RECOVER_CYC - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                rd_n_d  = 1'b1;
            end
        endcase
    end

    // Strobe FSM registers; reset releases the strobe on the next edge
    always_ff @(posedge pll0_250MHz) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            rd_n_q  <= 1'b1;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            rd_n_q  <= rd_n_d;
            data_q  <= data_d;
        end
    end

    assign usb_rd_n = rd_n_q;

    // Register the CPU select and its previous value for fall detection
    always_ff @(posedge pll0_250MHz) begin
        if (reset) begin
            cs_q      <= 1'b0;
            cs_prev_q <= 1'b0;
        end else begin
            cs_q      <= usbRxD_cs;
            cs_prev_q <= cs_q;
        end
    end

    assign pop = cs_prev_q & ~cs_q & ~fifo_empty;

    usb_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (pll0_250MHz),
        .rst_i   (reset),
        .push_i  (push),
        .din_i   (data_q),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Registered CPU-facing head byte and status
    always_ff @(posedge pll0_250MHz) begin
        if (reset) begin
            rxd_q    <= 8'h00;
            status_q <= 8'h00;
        end else begin
            rxd_q    <= fifo_empty ? 8'h00 : fifo_dout;
            status_q <= pack_status(fifo_count != '0,
                                    !txe_sync,
                                    fifo_count == CW'(DEPTH));
        end
    end

    assign usbRxD    = rxd_q;
    assign usbStatus = status_q;

`ifdef USB_RX_IRQ_EN
    logic irq_q;

    // Interrupt follows RX_AVAIL with one register stage
    always_ff @(posedge pll0_250MHz) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (fifo_count != '0);
        end
    end

    assign rx_irq = irq_q;
`endif

endmodule
